// File: rtl/vreg_stream_reader.sv
// Read-side sequencer for the vector register file: fetches one row through the
// registered read port, snapshots it, then streams its elements lowest-first.
module vreg_stream_reader #(
  parameter int ELEM_W = 16,
  parameter int NELEM  = 64,
  parameter int AW     = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [AW-1:0]           req_vreg,
  input  logic [6:0]              req_len,
  output logic [AW-1:0]           raddr,
  input  logic [ELEM_W*NELEM-1:0] rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ELEM_W-1:0]       out_data,
  output logic [5:0]              out_idx,
  output logic                    out_last,
  output logic                    done
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a valid, once raised, stays up with stable payload until that edge.

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_STREAM} state_t;

  state_t                    state_q, state_d;
  logic [6:0]                len_q;
  logic [5:0]                idx_q;
  logic [ELEM_W*NELEM-1:0]   row_buf;
  logic                      accept;
  logic                      is_last;
  logic [6:0]                len_clamped;

  assign len_clamped = (req_len > 7'(NELEM)) ? 7'(NELEM) : req_len;
  assign is_last     = ({1'b0, idx_q} == (len_q - 7'd1));

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = (req_len == 7'd0) ? S_IDLE : S_ISSUE;
        end
      end
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_STREAM;
      S_STREAM: begin
        out_valid = 1'b1;
        if (out_ready && is_last) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  assign out_last = out_valid && is_last;
  assign out_idx  = idx_q;
  assign out_data = row_buf[idx_q*ELEM_W +: ELEM_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      raddr   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      row_buf <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (accept) begin
        raddr <= req_vreg;
        len_q <= len_clamped;
        if (req_len == 7'd0) done <= 1'b1;
      end
      // rdata is valid during CAPTURE, one cycle after the file sampled raddr
      if (state_q == S_CAPTURE) begin
        row_buf <= rdata;
        idx_q   <= '0;
      end
      // The last element stops idx at len-1, so a 64-element stream never wraps
      if (out_valid && out_ready) begin
        if (is_last) done <= 1'b1;
        else         idx_q <= idx_q + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_vreg_stream_reader.sv
// Self-checking bench for vreg_stream_reader: a behavioural register file plus a
// scoreboard of expected elements derived from the file contents.
module tb_vreg_stream_reader;
  localparam int EW = 16;
  localparam int NE = 64;
  localparam int AW = 6;
  localparam int RW = EW * NE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_ready, out_valid, out_ready, out_last, done;
  logic [AW-1:0] req_vreg, raddr;
  logic [6:0]    req_len;
  logic [RW-1:0] rdata;
  logic [EW-1:0] out_data;
  logic [5:0]    out_idx;

  vreg_stream_reader #(.ELEM_W(EW), .NELEM(NE), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vreg(req_vreg), .req_len(req_len), .raddr(raddr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- register file model ----------------
  logic [RW-1:0] mem [16];
  logic [RW-1:0] shadow [16];
  logic [3:0]    file_ra;
  logic          we;
  logic [3:0]    waddr;
  logic [RW-1:0] wrow;
  always @(posedge clk) begin
    if (we) mem[waddr] <= wrow;
    file_ra <= raddr[3:0];
  end
  assign rdata = mem[file_ra];

  // ---------------- scoreboard ----------------
  logic [22:0] exp_q[$];
  int          hs_cyc_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          valid_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [22:0] held;
  logic [22:0] e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic void enqueue_row(input logic [RW-1:0] row, input logic [6:0] len);
    int n;
    n = (len > 7'd64) ? 64 : int'(len);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), 6'(i), row[i*EW +: EW]});
  endfunction

  function automatic int last_hs();
    return (hs_cyc_q.size() > 0) ? hs_cyc_q[hs_cyc_q.size()-1] : -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (out_valid) valid_cnt++;
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_payload", {out_last, out_idx, out_data}, held);
      end
      if (out_valid && out_ready) begin
        hs_cyc_q.push_back(cyc);
        check("elem_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("elem_data", out_data, e[15:0]);
          check("elem_idx", out_idx, e[21:16]);
          check("elem_last", out_last, e[22]);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_last, out_idx, out_data};
    end
  end

  // ---------------- drivers ----------------
  int         bp_mode = 0;
  int         pat_i = 0;
  logic [5:0] pat = 6'b101001;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_mode == 1) begin
      out_ready = pat[pat_i % 6];
      pat_i++;
    end else if (bp_mode == 2) begin
      out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic file_write(input logic [3:0] a, input logic [RW-1:0] row);
    we = 1'b1; waddr = a; wrow = row; shadow[a] = row;
    tick();
    we = 1'b0;
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int k = 0; k < RW / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic send_req(input logic [5:0] v, input logic [6:0] l, output int acc);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_vreg = v; req_len = l; acc = cyc;
    enqueue_row(shadow[v[3:0]], l);
    tick();
    req_valid = 1'b0; req_vreg = 6'($urandom()); req_len = 7'($urandom());
    check("raddr_after_accept", raddr, v);
  endtask

  task automatic wait_done(input string tag, input int budget, output int at);
    logic got;
    got = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin got = 1'b1; at = cyc; break; end
      tick();
    end
    check({tag, "_done_seen"}, got, 1);
  endtask

  // ---------------- stimulus ----------------
  int            acc, acc_b, dc, d0, v0, n;
  logic [RW-1:0] row, row_a, row_b;
  logic [5:0]    rv;
  logic [6:0]    rl;
  logic          found;

  initial begin
    req_valid = 0; req_vreg = 0; req_len = 0; out_ready = 1; we = 0; waddr = 0; wrow = 0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_raddr", raddr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);

    for (int v = 0; v < 16; v++) begin
      row = rand_row();
      if (v == 3) for (int i = 0; i < NE; i++) row[i*EW +: EW] = 16'(16'h1000 + i);
      file_write(4'(v), row);
    end
    rst_n = 1'b1;
    tick(); tick();

    // Full vector, with req_* noise while busy
    hs_cyc_q.delete(); d0 = done_cnt;
    send_req(6'd3, 7'd64, acc);
    for (int i = 0; i < 30; i++) begin
      tick();
      req_vreg = 6'($urandom()); req_len = 7'($urandom()); req_valid = 1'($urandom_range(0, 1));
    end
    req_valid = 1'b0;
    check("full_raddr_hold", raddr, 3);
    wait_done("full", 200, dc);
    check("full_done_cyc", dc, acc + 67);
    tick(); tick(); tick();
    check("full_done_once", done_cnt - d0, 1);
    check("full_hs_cnt", hs_cyc_q.size(), 64);
    check("full_first_hs", hs_cyc_q.size() > 0 ? hs_cyc_q[0] : -1, acc + 3);
    check("full_contig", last_hs() - (hs_cyc_q.size() > 0 ? hs_cyc_q[0] : 0), 63);
    check("full_q_empty", exp_q.size(), 0);

    // Backpressure, len 5
    hs_cyc_q.delete(); d0 = done_cnt; bp_mode = 1; pat_i = 0;
    send_req(6'd7, 7'd5, acc);
    wait_done("bp", 100, dc);
    bp_mode = 0; out_ready = 1'b1;
    tick();
    check("bp_hs_cnt", hs_cyc_q.size(), 5);
    check("bp_done_cyc", dc, last_hs() + 1);
    check("bp_done_once", done_cnt - d0, 1);
    check("bp_q_empty", exp_q.size(), 0);

    // len 0 then len 1
    v0 = valid_cnt; d0 = done_cnt;
    send_req(6'd2, 7'd0, acc);
    wait_done("len0", 5, dc);
    check("len0_done_cyc", dc, acc + 1);
    tick(); tick(); tick();
    check("len0_no_valid", valid_cnt - v0, 0);
    check("len0_done_once", done_cnt - d0, 1);
    hs_cyc_q.delete();
    send_req(6'd4, 7'd1, acc);
    wait_done("len1", 20, dc);
    tick();
    check("len1_hs_cnt", hs_cyc_q.size(), 1);
    check("len1_done_cyc", dc, acc + 4);

    // Write hazard on vreg 5
    row_a = rand_row(); row_b = rand_row(); hs_cyc_q.delete();
    send_req(6'd5, 7'd8, acc);
    exp_q.delete(); enqueue_row(row_a, 7'd8);
    we = 1'b1; waddr = 4'd5; wrow = row_a; shadow[5] = row_a;
    tick();
    we = 1'b0;
    tick();
    we = 1'b1; wrow = row_b; shadow[5] = row_b;
    tick();
    we = 1'b0;
    wait_done("hazard", 50, dc);
    tick();
    check("hazard_hs_cnt", hs_cyc_q.size(), 8);
    check("hazard_q_empty", exp_q.size(), 0);

    // Back-to-back: B held on req_valid while A runs
    hs_cyc_q.delete(); d0 = done_cnt;
    req_valid = 1'b1; req_vreg = 6'd1; req_len = 7'd2; acc = cyc;
    enqueue_row(shadow[1], 7'd2); enqueue_row(shadow[2], 7'd3);
    tick();
    req_vreg = 6'd2; req_len = 7'd3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req_ready) begin found = 1'b1; break; end
    end
    check("b2b_ready_seen", found, 1);
    check("b2b_done_with_accept", done, 1);
    acc_b = cyc;
    check("b2b_accept_cyc", acc_b, acc + 5);
    tick();
    req_valid = 1'b0;
    check("b2b_raddr_b", raddr, 2);
    wait_done("b2b", 50, dc);
    tick();
    check("b2b_hs_cnt", hs_cyc_q.size(), 5);
    check("b2b_gap", hs_cyc_q.size() == 5 ? hs_cyc_q[2] - hs_cyc_q[1] : -1, 4);
    check("b2b_done_cnt", done_cnt - d0, 2);

    // Randomized requests, including illegal lengths and varied backpressure
    for (int t = 0; t < 10; t++) begin
      rv = 6'($urandom_range(0, 63));
      rl = 7'($urandom_range(0, 72));
      if ($urandom_range(0, 1) == 1) file_write(rv[3:0], rand_row());
      hs_cyc_q.delete(); d0 = done_cnt;
      bp_mode = $urandom_range(0, 2);
      send_req(rv, rl, acc);
      wait_done("rand", 600, dc);
      bp_mode = 0; out_ready = 1'b1;
      tick();
      n = (rl > 7'd64) ? 64 : int'(rl);
      check("rand_hs_cnt", hs_cyc_q.size(), n);
      check("rand_done_once", done_cnt - d0, 1);
      check("rand_done_cyc", dc, (n == 0) ? acc + 1 : last_hs() + 1);
      check("rand_q_empty", exp_q.size(), 0);
    end

    // Reset in the middle of a 64-element stream
    send_req(6'd3, 7'd64, acc);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_valid && out_idx == 6'd10) begin found = 1'b1; break; end
    end
    check("mid_idx10_seen", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_req_ready", req_ready, 1);
    check("mid_raddr", raddr, 0);
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    check("mid_out_idx", out_idx, 0);
    check("mid_out_last", out_last, 0);
    check("mid_done", done, 0);
    exp_q.delete(); d0 = done_cnt;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("mid_no_done", done_cnt - d0, 0);
    hs_cyc_q.delete();
    send_req(6'd6, 7'd3, acc);
    wait_done("post_rst", 30, dc);
    tick();
    check("post_rst_hs_cnt", hs_cyc_q.size(), 3);
    check("post_rst_done_cyc", dc, acc + 6);
    check("post_rst_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got cycle %0d required finish before limit", cyc);
    $fatal(1);
  end

endmodule
